// File: rtl/h_matrix_bank.sv
// Ping-pong bank holding two 4x8 complex H matrices.
// Ports: row capture (row_valid, in_rowHr*/Hi*), h_valid/h_ack handshake, registered read port, status.
module h_matrix_bank #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          row_valid,
  input  logic [2*DW-1:0] in_rowHr0,
  input  logic [2*DW-1:0] in_rowHr1,
  input  logic [2*DW-1:0] in_rowHr2,
  input  logic [2*DW-1:0] in_rowHr3,
  input  logic [2*DW-1:0] in_rowHi0,
  input  logic [2*DW-1:0] in_rowHi1,
  input  logic [2*DW-1:0] in_rowHi2,
  input  logic [2*DW-1:0] in_rowHi3,
  output logic          h_valid,
  input  logic          h_ack,
  input  logic          rd_en,
  input  logic [1:0]    rd_row,
  input  logic [2:0]    rd_col,
  output logic [DW-1:0] rd_re,
  output logic [DW-1:0] rd_im,
  output logic          rd_valid,
  output logic          overflow,
  output logic [1:0]    rows_in_bank
);

  logic [DW-1:0] mem_re [2][4][8];
  logic [DW-1:0] mem_im [2][4][8];

  logic       wr_bank;
  logic       rd_bank;
  logic [1:0] row_cnt;
  logic [1:0] full;
  logic [1:0] full_nxt;

  logic [2*DW-1:0] w_re [4];
  logic [2*DW-1:0] w_im [4];
  logic [DW-1:0]   col_re [8];
  logic [DW-1:0]   col_im [8];

  logic cap;
  logic drop;
  logic ack;

  assign w_re[0] = in_rowHr0;
  assign w_re[1] = in_rowHr1;
  assign w_re[2] = in_rowHr2;
  assign w_re[3] = in_rowHr3;
  assign w_im[0] = in_rowHi0;
  assign w_im[1] = in_rowHi1;
  assign w_im[2] = in_rowHi2;
  assign w_im[3] = in_rowHi3;

  // word k: even column in the upper half, odd column in the lower half
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      col_re[2*k]   = w_re[k][2*DW-1:DW];
      col_re[2*k+1] = w_re[k][DW-1:0];
      col_im[2*k]   = w_im[k][2*DW-1:DW];
      col_im[2*k+1] = w_im[k][DW-1:0];
    end
  end

  assign cap  = row_valid & ~full[wr_bank];
  assign drop = row_valid & full[wr_bank];
  assign ack  = h_ack & full[rd_bank];

  // completion and ack never hit the same bank, so both updates apply
  always_comb begin
    full_nxt = full;
    if (ack)
      full_nxt[rd_bank] = 1'b0;
    if (cap && row_cnt == 2'd3)
      full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      row_cnt  <= 2'd0;
      full     <= 2'b00;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_re    <= '0;
      rd_im    <= '0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 8; c++) begin
            mem_re[b][r][c] <= '0;
            mem_im[b][r][c] <= '0;
          end
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_re <= mem_re[rd_bank][rd_row][rd_col];
        rd_im <= mem_im[rd_bank][rd_row][rd_col];
      end
      if (clear) begin
        wr_bank <= 1'b0;
        rd_bank <= 1'b0;
        row_cnt <= 2'd0;
        full    <= 2'b00;
      end else begin
        if (drop)
          overflow <= 1'b1;
        if (cap) begin
          for (int c = 0; c < 8; c++) begin
            mem_re[wr_bank][row_cnt][c] <= col_re[c];
            mem_im[wr_bank][row_cnt][c] <= col_im[c];
          end
          row_cnt <= row_cnt + 2'd1;
          if (row_cnt == 2'd3)
            wr_bank <= ~wr_bank;
        end
        if (ack)
          rd_bank <= ~rd_bank;
        full <= full_nxt;
      end
    end
  end

  assign h_valid      = full[rd_bank];
  assign rows_in_bank = row_cnt;

endmodule

// File: tb/tb_h_matrix_bank.sv
// Self-checking bench for h_matrix_bank.
// Random and directed stimulus against a count-based matrix model.
module tb_h_matrix_bank;

  logic        clk = 1'b0;
  logic        rst, clear, row_valid, h_ack, rd_en;
  logic [31:0] hr [4];
  logic [31:0] hi [4];
  logic [1:0]  rd_row;
  logic [2:0]  rd_col;
  logic        h_valid, rd_valid, overflow;
  logic [15:0] rd_re, rd_im;
  logic [1:0]  rows_in_bank;

  int n_pass = 0;
  int n_total = 0;

  // model: banks fill and drain strictly in order, so bank ids follow counts
  logic [15:0] m_re [2][4][8];
  logic [15:0] m_im [2][4][8];
  int          comp, acks, rows;
  logic        m_ovf, m_rdv;
  logic [15:0] m_rre, m_rim;

  h_matrix_bank #(.DW(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .row_valid(row_valid),
    .in_rowHr0(hr[0]), .in_rowHr1(hr[1]),
    .in_rowHr2(hr[2]), .in_rowHr3(hr[3]),
    .in_rowHi0(hi[0]), .in_rowHi1(hi[1]),
    .in_rowHi2(hi[2]), .in_rowHi3(hi[3]),
    .h_valid(h_valid), .h_ack(h_ack),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .rd_re(rd_re), .rd_im(rd_im), .rd_valid(rd_valid),
    .overflow(overflow), .rows_in_bank(rows_in_bank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] half(input logic [31:0] w, input int c);
    return (c % 2 == 0) ? w[31:16] : w[15:0];
  endfunction

  task automatic model_step();
    int pend;
    int rb;
    if (rst) begin
      comp = 0; acks = 0; rows = 0;
      m_ovf = 0; m_rdv = 0; m_rre = 0; m_rim = 0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 8; c++) begin
            m_re[b][r][c] = 0;
            m_im[b][r][c] = 0;
          end
      return;
    end
    rb = acks % 2;
    m_rdv = rd_en;
    if (rd_en) begin
      m_rre = m_re[rb][rd_row][rd_col];
      m_rim = m_im[rb][rd_row][rd_col];
    end
    if (clear) begin
      comp = 0; acks = 0; rows = 0;
      return;
    end
    pend = comp - acks;
    if (row_valid) begin
      if (pend == 2) m_ovf = 1;
      else begin
        for (int c = 0; c < 8; c++) begin
          m_re[comp % 2][rows][c] = half(hr[c / 2], c);
          m_im[comp % 2][rows][c] = half(hi[c / 2], c);
        end
        rows++;
        if (rows == 4) begin
          rows = 0;
          comp++;
        end
      end
    end
    if (h_ack && pend > 0) acks++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("h_valid", h_valid, (comp - acks) > 0);
    chk("rows_in_bank", rows_in_bank, rows[1:0]);
    chk("overflow", overflow, m_ovf);
    chk("rd_valid", rd_valid, m_rdv);
    chk("rd_re", rd_re, m_rre);
    chk("rd_im", rd_im, m_rim);
    rst = 0; clear = 0; row_valid = 0; h_ack = 0; rd_en = 0;
  endtask

  task automatic set_row(input int r);
    logic [3:0] n;
    n = r[3:0];
    row_valid = 1;
    hr[0] = {4'h0, n, 8'h00, 4'h0, n, 8'h01};
    for (int k = 1; k < 4; k++) hr[k] = $urandom;
    for (int k = 0; k < 4; k++) hi[k] = $urandom;
  endtask

  task automatic rows_n(input int n);
    for (int i = 0; i < n; i++) begin
      set_row(i % 4);
      tick();
    end
  endtask

  task automatic rd(input int r, input int c);
    rd_en = 1;
    rd_row = r[1:0];
    rd_col = c[2:0];
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
  endtask

  initial begin
    rst = 1; clear = 0; row_valid = 0; h_ack = 0; rd_en = 0;
    rd_row = 0; rd_col = 0;
    for (int k = 0; k < 4; k++) begin
      hr[k] = 0;
      hi[k] = 0;
    end
    tick();

    // first matrix, readback
    rows_n(3);
    chk("hv_before_4th", h_valid, 0);
    rows_n(1);
    chk("hv_after_4th", h_valid, 1);
    rd(2, 1);
    tick();
    chk("rd_2_1", rd_re, 16'h0201);
    rd(0, 0);
    tick();
    chk("rd_0_0", rd_re, 16'h0000);

    // both banks full then drop
    rows_n(4);
    chk("both_full_hv", h_valid, 1);
    set_row(9);
    tick();
    chk("drop_ovf", overflow, 1);
    chk("drop_rows", rows_in_bank, 0);
    h_ack = 1;
    tick();
    chk("ack_hv_stays", h_valid, 1);
    rd(1, 3);
    tick();

    // completion and ack together
    do_reset();
    rows_n(7);
    set_row(3);
    h_ack = 1;
    tick();
    chk("comp_ack_hv", h_valid, 1);
    rd(3, 7);
    tick();

    // clear mid-matrix
    do_reset();
    rows_n(2);
    clear = 1;
    tick();
    chk("clear_rows", rows_in_bank, 0);
    chk("clear_hv", h_valid, 0);
    rows_n(4);
    chk("refill_hv", h_valid, 1);
    rd(3, 6);
    tick();

    // reset while busy
    do_reset();
    rows_n(7);
    rd(1, 2);
    tick();
    chk("pre_rst_rows", rows_in_bank, 3);
    do_reset();
    chk("rst_hv", h_valid, 0);
    chk("rst_re", rd_re, 0);
    chk("rst_ovf", overflow, 0);
    rd(1, 2);
    tick();
    chk("rst_read_zero", rd_re, 0);

    // read during ack
    rows_n(8);
    rd(2, 5);
    h_ack = 1;
    tick();
    rd(2, 5);
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      row_valid = ($urandom_range(1) == 1);
      for (int k = 0; k < 4; k++) begin
        hr[k] = $urandom;
        hi[k] = $urandom;
      end
      h_ack = ($urandom_range(3) == 0);
      rd_en = ($urandom_range(1) == 1);
      rd_row = 2'($urandom_range(3));
      rd_col = 3'($urandom_range(7));
      clear = ($urandom_range(63) == 0);
      rst = ($urandom_range(127) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
